// File: rtl/mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl
//
// Execute-stage control in front of the multiplier. Accepts a multiply from
// the EX pipeline register, latches its op code and operands, fires a
// one-cycle start pulse at the multiplier and holds EX until the result is
// back. It then keeps the result until MEM takes it. A flush while the
// multiplier is running cannot abort the multiplier, so the block drains it
// and throws the result away. A watchdog forces a return to IDLE if the
// multiplier never answers.
//
// Ports
//   clk            clock, all state on the rising edge
//   reset          asynchronous reset, active low (0 = reset)
//   es_valid       EX holds a valid instruction
//   es_flush       exception/ertn flush of EX (level)
//   mul_div_op     one-hot op from decode; [2:0] nonzero marks a multiply
//   alu_src1/2     operands from EX
//   ms_allowin     MEM can accept this cycle
//   mult           one-cycle start pulse to the multiplier
//   mul_op         latched op code to the multiplier
//   mul_src1/2     latched operands to the multiplier
//   mul_result     multiplier result
//   mul_done       multiplier completion
//   es_mul_stall   hold the EX stage
//   es_mul_result  captured result
//   es_mul_valid   es_mul_result is valid for MEM
//   mul_timeout    one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module mul_issue_ctrl #(
  parameter int MAX_LAT = 40,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_valid,
  input  logic        es_flush,
  input  logic [9:0]  mul_div_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  input  logic        ms_allowin,
  output logic        mult,
  output logic [9:0]  mul_op,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_result,
  input  logic        mul_done,
  output logic        es_mul_stall,
  output logic [31:0] es_mul_result,
  output logic        es_mul_valid,
  output logic        mul_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q,   state_d;
  logic [9:0]  op_q,      op_d;
  logic [31:0] src1_q,    src1_d;
  logic [31:0] src2_q,    src2_d;
  logic        mult_q,    mult_d;
  logic [31:0] result_q,  result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  logic req;
  logic wd_expire;
  logic done_ok;

  assign req       = es_valid & (|mul_div_op[2:0]) & ~es_flush;
  assign wd_expire = (cnt_q == CNT_W'(MAX_LAT - 1));
  // The multiplier cannot finish in the same cycle it is started, so a
  // mul_done seen alongside the start pulse is treated as stale.
  assign done_ok   = mul_done & ~mult_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    mult_d    = 1'b0;
    result_d  = result_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          op_d    = mul_div_op;
          src1_d  = alu_src1;
          src2_d  = alu_src2;
          mult_d  = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (done_ok && es_flush) begin
          state_d = IDLE;
        end else if (done_ok) begin
          result_d = mul_result;
          state_d  = DONE;
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (es_flush) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        // Flush and MEM acceptance both lead to IDLE; the result register
        // is left alone either way.
        if (es_flush || ms_allowin) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // The watchdog keeps counting from where BUSY left off.
        cnt_d = cnt_q + 1'b1;
        if (mul_done) begin
          state_d = IDLE;
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      mult_q    <= 1'b0;
      result_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      mult_q    <= mult_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Stall is combinational on live inputs; it is gated by reset so that
  // every output reads 0 the moment reset is asserted.
  always_comb begin
    es_mul_stall = 1'b0;
    unique case (state_q)
      IDLE:    es_mul_stall = req;
      BUSY:    es_mul_stall = ~es_flush;
      DONE:    es_mul_stall = ~ms_allowin & ~es_flush;
      DRAIN:   es_mul_stall = req;
      default: es_mul_stall = 1'b0;
    endcase
    es_mul_stall = es_mul_stall & reset;
  end

  assign mult          = mult_q;
  assign mul_op        = op_q;
  assign mul_src1      = src1_q;
  assign mul_src2      = src2_q;
  assign es_mul_result = result_q;
  assign es_mul_valid  = (state_q == DONE);
  assign mul_timeout   = timeout_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul_issue_ctrl
//
// Directed bench for mul_issue_ctrl. Each cycle the inputs are driven a
// couple of time units after the rising edge and the outputs are checked
// shortly after that, well clear of the next edge. Expected values are
// worked out by hand from the cycle-by-cycle behaviour of the block.
// ---------------------------------------------------------------------------
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_valid;
  logic        es_flush;
  logic [9:0]  mul_div_op;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic        ms_allowin;
  logic        mult;
  logic [9:0]  mul_op;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic [31:0] mul_result;
  logic        mul_done;
  logic        es_mul_stall;
  logic [31:0] es_mul_result;
  logic        es_mul_valid;
  logic        mul_timeout;

  int assertCount = 0;
  int failCount   = 0;

  mul_issue_ctrl #(.MAX_LAT(40), .CNT_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .es_valid      (es_valid),
    .es_flush      (es_flush),
    .mul_div_op    (mul_div_op),
    .alu_src1      (alu_src1),
    .alu_src2      (alu_src2),
    .ms_allowin    (ms_allowin),
    .mult          (mult),
    .mul_op        (mul_op),
    .mul_src1      (mul_src1),
    .mul_src2      (mul_src2),
    .mul_result    (mul_result),
    .mul_done      (mul_done),
    .es_mul_stall  (es_mul_stall),
    .es_mul_result (es_mul_result),
    .es_mul_valid  (es_mul_valid),
    .mul_timeout   (mul_timeout)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives every input of the block, then lets combinational logic settle.
  task automatic applyStimulus(input logic valid, input logic flush,
                               input logic [9:0] op, input logic [31:0] s1,
                               input logic [31:0] s2, input logic allow,
                               input logic done, input logic [31:0] res);
    es_valid   = valid;
    es_flush   = flush;
    mul_div_op = op;
    alu_src1   = s1;
    alu_src2   = s2;
    ms_allowin = allow;
    mul_done   = done;
    mul_result = res;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Drives quiet inputs: no request, no flush, MEM ready, no done.
  task automatic quiet();
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mult"},   {31'd0, mult},         32'd0);
    checkOutput({tag, "_op"},     {22'd0, mul_op},       32'd0);
    checkOutput({tag, "_src1"},   mul_src1,              32'd0);
    checkOutput({tag, "_src2"},   mul_src2,              32'd0);
    checkOutput({tag, "_stall"},  {31'd0, es_mul_stall}, 32'd0);
    checkOutput({tag, "_valid"},  {31'd0, es_mul_valid}, 32'd0);
    checkOutput({tag, "_result"}, es_mul_result,         32'd0);
    checkOutput({tag, "_tmo"},    {31'd0, mul_timeout},  32'd0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b0;
    quiet();
    #2;
    checkAllZero("rst");
    @(posedge clk);
    #2;
    reset = 1'b1;
    nextCycle();

    // ---------------- basic op: 7 * 6 ----------------
    applyStimulus(1'b1, 1'b0, 10'b001, 32'd7, 32'd6, 1'b1, 1'b0, 32'd0);
    checkOutput("b_req_stall", {31'd0, es_mul_stall}, 32'd1);
    checkOutput("b_req_mult",  {31'd0, mult},         32'd0);
    nextCycle();
    quiet();
    checkOutput("b_mult",  {31'd0, mult},         32'd1);
    checkOutput("b_stall", {31'd0, es_mul_stall}, 32'd1);
    checkOutput("b_op",    {22'd0, mul_op},       32'd1);
    checkOutput("b_src1",  mul_src1,              32'd7);
    checkOutput("b_src2",  mul_src2,              32'd6);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("b_busy_mult",  {31'd0, mult},         32'd0);
      checkOutput("b_busy_stall", {31'd0, es_mul_stall}, 32'd1);
      checkOutput("b_busy_valid", {31'd0, es_mul_valid}, 32'd0);
    end
    nextCycle();
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd42);
    checkOutput("b_done_stall", {31'd0, es_mul_stall}, 32'd1);
    nextCycle();
    quiet();
    checkOutput("b_valid",    {31'd0, es_mul_valid}, 32'd1);
    checkOutput("b_result",   es_mul_result,         32'd42);
    checkOutput("b_rel_stall", {31'd0, es_mul_stall}, 32'd0);
    nextCycle();
    checkOutput("b_after_valid",  {31'd0, es_mul_valid}, 32'd0);
    checkOutput("b_after_result", es_mul_result,         32'd42);

    // ---------------- MEM backpressure ----------------
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'b001, 32'h100, 32'h12, 1'b0, 1'b0, 32'd0);
    nextCycle();
    // done in the start cycle must be ignored
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hBAD);
    checkOutput("bp_mult", {31'd0, mult}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1200);
    checkOutput("bp_ign_valid", {31'd0, es_mul_valid}, 32'd0);
    checkOutput("bp_ign_stall", {31'd0, es_mul_stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h0);
      checkOutput("bp_hold_valid",  {31'd0, es_mul_valid}, 32'd1);
      checkOutput("bp_hold_stall",  {31'd0, es_mul_stall}, 32'd1);
      checkOutput("bp_hold_result", es_mul_result,         32'h1200);
    end
    nextCycle();
    quiet();
    checkOutput("bp_rel_valid", {31'd0, es_mul_valid}, 32'd1);
    checkOutput("bp_rel_stall", {31'd0, es_mul_stall}, 32'd0);
    nextCycle();
    checkOutput("bp_idle_valid", {31'd0, es_mul_valid}, 32'd0);

    // ---------------- flush in BUSY, then drain ----------------
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'b001, 32'd3, 32'd5, 1'b1, 1'b0, 32'd0);
    nextCycle();
    quiet();
    checkOutput("fl_mult", {31'd0, mult}, 32'd1);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b1, 10'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    checkOutput("fl_flush_stall", {31'd0, es_mul_stall}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'b010, 32'd9, 32'd9, 1'b1, 1'b0, 32'd0);
    checkOutput("fl_drain_stall", {31'd0, es_mul_stall}, 32'd1);
    checkOutput("fl_drain_mult",  {31'd0, mult},         32'd0);
    checkOutput("fl_drain_src1",  mul_src1,              32'd3);
    nextCycle();
    checkOutput("fl_drain2_stall", {31'd0, es_mul_stall}, 32'd1);
    checkOutput("fl_drain2_op",    {22'd0, mul_op},       32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'b010, 32'd9, 32'd9, 1'b1, 1'b1, 32'hDEAD);
    checkOutput("fl_ddone_stall", {31'd0, es_mul_stall}, 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'b010, 32'd9, 32'd9, 1'b1, 1'b0, 32'd0);
    checkOutput("fl_idle_valid",  {31'd0, es_mul_valid}, 32'd0);
    checkOutput("fl_idle_stall",  {31'd0, es_mul_stall}, 32'd1);
    checkOutput("fl_idle_mult",   {31'd0, mult},         32'd0);
    checkOutput("fl_idle_result", es_mul_result,         32'h1200);
    nextCycle();
    quiet();
    checkOutput("fl_new_mult", {31'd0, mult},   32'd1);
    checkOutput("fl_new_op",   {22'd0, mul_op}, 32'd2);
    checkOutput("fl_new_src1", mul_src1,        32'd9);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd81);
    nextCycle();
    quiet();
    checkOutput("fl_new_valid",  {31'd0, es_mul_valid}, 32'd1);
    checkOutput("fl_new_result", es_mul_result,         32'd81);
    nextCycle();
    checkOutput("fl_new_after", {31'd0, es_mul_valid}, 32'd0);

    // ---------------- flush and done together in BUSY ----------------
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'b001, 32'd4, 32'd4, 1'b1, 1'b0, 32'd0);
    nextCycle();
    quiet();
    checkOutput("fd_mult", {31'd0, mult}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 10'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h55);
    checkOutput("fd_stall", {31'd0, es_mul_stall}, 32'd0);
    nextCycle();
    quiet();
    checkOutput("fd_valid",  {31'd0, es_mul_valid}, 32'd0);
    checkOutput("fd_result", es_mul_result,         32'd81);
    checkOutput("fd_stall2", {31'd0, es_mul_stall}, 32'd0);
    nextCycle();
    checkOutput("fd_valid2", {31'd0, es_mul_valid}, 32'd0);

    // ---------------- watchdog ----------------
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'b100, 32'd1, 32'd1, 1'b1, 1'b0, 32'd0);
    nextCycle();
    quiet();
    checkOutput("wd_mult", {31'd0, mult}, 32'd1);
    for (int i = 2; i <= 40; i++) begin
      nextCycle();
      checkOutput("wd_wait_tmo",   {31'd0, mul_timeout},  32'd0);
      checkOutput("wd_wait_stall", {31'd0, es_mul_stall}, 32'd1);
    end
    nextCycle();
    checkOutput("wd_tmo",   {31'd0, mul_timeout},  32'd1);
    checkOutput("wd_stall", {31'd0, es_mul_stall}, 32'd0);
    checkOutput("wd_valid", {31'd0, es_mul_valid}, 32'd0);
    nextCycle();
    checkOutput("wd_tmo_once", {31'd0, mul_timeout}, 32'd0);

    // ---------------- async reset mid-BUSY ----------------
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd0);
    nextCycle();
    checkOutput("ar_mult",  {31'd0, mult},         32'd1);
    checkOutput("ar_src1",  mul_src1,              32'hFFFFFFFF);
    checkOutput("ar_src2",  mul_src2,              32'hFFFFFFFF);
    checkOutput("ar_stall", {31'd0, es_mul_stall}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkAllZero("ar_async");
    nextCycle();
    checkAllZero("ar_held");
    quiet();
    reset = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 1'b0, 10'b001, 32'd2, 32'd3, 1'b1, 1'b0, 32'd0);
    checkOutput("ar_re_stall", {31'd0, es_mul_stall}, 32'd1);
    nextCycle();
    quiet();
    checkOutput("ar_re_mult", {31'd0, mult}, 32'd1);
    checkOutput("ar_re_src1", mul_src1,      32'd2);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd6);
    nextCycle();
    quiet();
    checkOutput("ar_re_valid",  {31'd0, es_mul_valid}, 32'd1);
    checkOutput("ar_re_result", es_mul_result,         32'd6);
    nextCycle();
    checkOutput("ar_re_after", {31'd0, es_mul_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
